vga_timing_pattern_gen: RTL and testbench

- Parametrised VGA timing generator with a built-in test-pattern engine. It is the successor to the fixed 640x480 sync generator.
- Runs at pixel rate on vga_clk, which the top level derives from CLOCK_50.
- Drives HS, VS, blank_n, pixel coordinates and 24-bit RGB, all mutually aligned, straight to the VGA DAC pins.
- Adds configurable timing and sync polarity, four pattern modes latched at frame boundaries, and a frame counter for animated patterns.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_pattern_color.sv | 68 ++++++
 rtl/vga_timing_pattern_gen.sv | 136 +++++++++++++
 tb/tb_vga_timing_pattern_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing / test-pattern generator:
// 640x480@60 default timing, pattern mode encodings and the colour-bar index helper.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_t;

    // Bar number under column xv, saturating at the last (black) bar.
    function automatic logic [2:0] bar_index(input int xv, input int bar_w);
        int q;
        q = xv / bar_w;
        return (q > 7) ? 3'd7 : q[2:0];
    endfunction

endpackage

// File: rtl/vga_pattern_color.sv
// Stage-2 colour registers: turns a stage-1 pixel position into registered RGB
// for the latched pattern mode. Output is forced to black while blanked.
module vga_pattern_color
    import vga_pkg::*;
#(
    parameter int CW         = 10,
    parameter int BAR_W      = 80,
    parameter int CHECK_LOG2 = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode_q,
    input  logic [23:0]   rgb_q,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          blank,
    input  logic [7:0]    frame_cnt,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b
);

    logic [7:0]    r_next, g_next, b_next;
    logic [2:0]    idx;
    logic [CW-1:0] sum;
    logic          chk;

    always_comb begin
        r_next = 8'h00;
        g_next = 8'h00;
        b_next = 8'h00;
        idx    = bar_index(32'(x), BAR_W);
        // Adding frame_cnt to x moves the checker left by one pixel per frame.
        sum    = x + CW'(frame_cnt);
        chk    = sum[CHECK_LOG2] ^ y[CHECK_LOG2];
        case (mode_t'(mode_q))
            MODE_SOLID: {r_next, g_next, b_next} = rgb_q;
            MODE_BARS: begin
                r_next = {8{~idx[1]}};
                g_next = {8{~idx[2]}};
                b_next = {8{~idx[0]}};
            end
            MODE_CHECK: {r_next, g_next, b_next} = {24{chk}};
            MODE_GRAD: begin
                r_next = 8'(x);
                g_next = 8'(y);
                b_next = frame_cnt;
            end
            default: {r_next, g_next, b_next} = 24'h0;
        endcase
        if (blank) begin
            {r_next, g_next, b_next} = 24'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r <= 8'h00;
            g <= 8'h00;
            b <= 8'h00;
        end else begin
            r <= r_next;
            g <= g_next;
            b <= b_next;
        end
    end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator with test-pattern engine. Counters, sync decode
// and alignment delays live here; every output lags the counters by exactly two cycles.
module vga_timing_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CW         = 10,
    parameter int BAR_W      = 80,
    parameter int CHECK_LOG2 = 5
) (
    input  logic          vga_clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    output logic          HS,
    output logic          VS,
    output logic          blank_n,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic [7:0]    frame_cnt,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_last, v_last, frame_end;
    logic          h_sync, v_sync;
    logic [1:0]    mode_q;
    logic [23:0]   rgb_q;

    logic          s1_hs, s1_vs, s1_blank_n, s1_fs;
    logic [CW-1:0] s1_x, s1_y;

    assign h_last    = (h_cnt == CW'(H_TOTAL - 1));
    assign v_last    = (v_cnt == CW'(V_TOTAL - 1));
    assign frame_end = h_last && v_last;
    assign h_sync    = (h_cnt >= CW'(H_ACTIVE + H_FP)) && (h_cnt < CW'(H_ACTIVE + H_FP + H_SYNC));
    assign v_sync    = (v_cnt >= CW'(V_ACTIVE + V_FP)) && (v_cnt < CW'(V_ACTIVE + V_FP + V_SYNC));

    // Stage 0: pixel/line counters
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Pattern controls only change between frames so a frame is never torn.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            mode_q    <= 2'd0;
            rgb_q     <= 24'h0;
            frame_cnt <= 8'h00;
        end else if (frame_end) begin
            mode_q    <= mode;
            rgb_q     <= solid_rgb;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Stage 1: decoded sync/blank and coordinates
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            s1_hs      <= ~HS_POL;
            s1_vs      <= ~VS_POL;
            s1_blank_n <= 1'b0;
            s1_fs      <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
        end else begin
            s1_hs      <= h_sync ? HS_POL : ~HS_POL;
            s1_vs      <= v_sync ? VS_POL : ~VS_POL;
            s1_blank_n <= (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
            s1_fs      <= (h_cnt == '0) && (v_cnt == '0);
            s1_x       <= h_cnt;
            s1_y       <= v_cnt;
        end
    end

    // Stage 2: delay timing one more cycle to line up with the colour registers
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            HS          <= s1_hs;
            VS          <= s1_vs;
            blank_n     <= s1_blank_n;
            frame_start <= s1_fs;
            x           <= s1_x;
            y           <= s1_y;
        end
    end

    vga_pattern_color #(
        .CW         (CW),
        .BAR_W      (BAR_W),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_color (
        .clk        (vga_clk),
        .reset      (reset),
        .mode_q     (mode_q),
        .rgb_q      (rgb_q),
        .x          (s1_x),
        .y          (s1_y),
        .blank      (~s1_blank_n),
        .frame_cnt  (frame_cnt),
        .r          (VGA_R),
        .g          (VGA_G),
        .b          (VGA_B)
    );

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen using a shrunken 24x9 raster so hundreds of frames fit
// in a short run; a second instance covers active-high sync polarity.
module tb_vga_timing_pattern_gen;

    localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VA = 6, VF = 1, VSY = 1, VB = 1;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int BW = 2, CL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;

    logic        hs, vs, blank_n, frame_start;
    logic [9:0]  x, y;
    logic [7:0]  frame_cnt, vga_r, vga_g, vga_b;
    logic        hs2, vs2, blank_n2, frame_start2;
    logic [9:0]  x2, y2;
    logic [7:0]  frame_cnt2, vga_r2, vga_g2, vga_b2;

    int checks = 0;
    int failures = 0;
    int k = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          pos;
        string       name;
        logic        hs, vs, bl, fs;
        logic [23:0] rgb;
        logic [7:0]  fc;
        int          px, py;
    } exp_t;
    exp_t exp_q[$];

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .BAR_W(BW), .CHECK_LOG2(CL)
    ) dut (
        .vga_clk(clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
        .HS(hs), .VS(vs), .blank_n(blank_n), .x(x), .y(y),
        .frame_start(frame_start), .frame_cnt(frame_cnt),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b)
    );

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .BAR_W(BW), .CHECK_LOG2(CL)
    ) dut_pos (
        .vga_clk(clk), .reset(reset), .mode(mode), .solid_rgb(solid_rgb),
        .HS(hs2), .VS(vs2), .blank_n(blank_n2), .x(x2), .y(y2),
        .frame_start(frame_start2), .frame_cnt(frame_cnt2),
        .VGA_R(vga_r2), .VGA_G(vga_g2), .VGA_B(vga_b2)
    );

    // clock / reset-relative cycle count (k = counter position of the DUT)
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic void expect_px(input string nm, input int f, input int h, input int v,
                                      input logic [23:0] rgb);
        exp_t e;
        int   i;
        e.pos  = f * FRAME + v * HT + h;
        e.name = nm;
        e.bl   = (h < HA) && (v < VA);
        e.hs   = !((h >= HA + HF) && (h < HA + HF + HSY));
        e.vs   = !((v >= VA + VF) && (v < VA + VF + VSY));
        e.fs   = (h == 0) && (v == 0);
        e.fc   = 8'(f % 256);
        e.rgb  = e.bl ? rgb : 24'h0;
        e.px   = h;
        e.py   = v;
        i = 0;
        while (i < exp_q.size() && exp_q[i].pos <= e.pos) i++;
        exp_q.insert(i, e);
    endfunction

    task automatic wait_k(input int t);
        while (k < t) @(negedge clk);
    endtask

    // driver
    initial begin
        reset = 1'b1;
        mode = 2'd0;
        solid_rgb = 24'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        mode = 2'd1;
        solid_rgb = 24'h777777;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d.hs", i), 32'(hs), 1);
            check($sformatf("rst%0d.vs", i), 32'(vs), 1);
            check($sformatf("rst%0d.blank_n", i), 32'(blank_n), 0);
            check($sformatf("rst%0d.rgb", i), 32'({vga_r, vga_g, vga_b}), 0);
            check($sformatf("rst%0d.fs", i), 32'(frame_start), 0);
            check($sformatf("rst%0d.fc", i), 32'(frame_cnt), 0);
            check($sformatf("rst%0d.hs_pos", i), 32'(hs2), 0);
            check($sformatf("rst%0d.vs_pos", i), 32'(vs2), 0);
        end

        expect_px("f0_hs_idle", 0, 17, 2, 24'h0);
        expect_px("f0_hs_start", 0, 18, 2, 24'h0);
        expect_px("f0_hs_end", 0, 20, 2, 24'h0);
        expect_px("f0_hs_after", 0, 21, 2, 24'h0);
        expect_px("f0_solid_rst", 0, 5, 3, 24'h0);
        expect_px("f0_hfp", 0, 16, 3, 24'h0);
        expect_px("f0_vfp", 0, 0, 6, 24'h0);
        expect_px("f0_vs_start", 0, 0, 7, 24'h0);
        expect_px("f0_vs_end", 0, 23, 7, 24'h0);
        expect_px("f0_vbp", 0, 0, 8, 24'h0);
        expect_px("bar_x0", 1, 0, 2, 24'hFFFFFF);
        expect_px("bar_x2", 1, 2, 2, 24'hFFFF00);
        expect_px("bar_x4", 1, 4, 2, 24'h00FFFF);
        expect_px("bar_x7", 1, 7, 2, 24'h00FF00);
        expect_px("bar_x10", 1, 10, 2, 24'hFF0000);
        expect_px("bar_x15", 1, 15, 2, 24'h000000);
        expect_px("bar_x16", 1, 16, 2, 24'h000000);
        expect_px("bar_late", 1, 4, 5, 24'h00FFFF);
        expect_px("f2_solid0", 2, 0, 0, 24'h123456);
        expect_px("f2_solid_late", 2, 10, 5, 24'h123456);
        expect_px("f3_grad0", 3, 0, 0, 24'h000003);
        expect_px("f3_grad_a", 3, 12, 4, 24'h0C0403);
        expect_px("f3_grad_b", 3, 15, 5, 24'h0F0503);
        expect_px("f4_edge0", 4, 0, 0, 24'h00FF00);
        expect_px("f4_edge_late", 4, 7, 3, 24'h00FF00);
        expect_px("f5_chk_0_0", 5, 0, 0, 24'hFFFFFF);
        expect_px("f5_chk_3_0", 5, 3, 0, 24'h000000);
        expect_px("f5_chk_0_4", 5, 0, 4, 24'h000000);
        expect_px("f5_chk_6_5", 5, 6, 5, 24'hFFFFFF);
        expect_px("f255_chk_0_0", 255, 0, 0, 24'hFFFFFF);
        expect_px("f255_chk_15_5", 255, 15, 5, 24'h000000);
        expect_px("f256_chk_0_0", 256, 0, 0, 24'h000000);
        expect_px("f256_chk_3_0", 256, 3, 0, 24'h000000);
        expect_px("f256_chk_4_0", 256, 4, 0, 24'hFFFFFF);
        expect_px("f257_chk_2_0", 257, 2, 0, 24'h000000);
        expect_px("f257_chk_3_0", 257, 3, 0, 24'hFFFFFF);

        mon_en = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("fs_release_1", 32'(frame_start), 0);
        @(negedge clk);
        check("fs_release_2", 32'(frame_start), 1);

        // mode/solid_rgb changes mid-frame take effect only at the next frame
        wait_k(FRAME + 100);
        mode = 2'd0; solid_rgb = 24'h123456;
        wait_k(2 * FRAME + 100);
        mode = 2'd3; solid_rgb = 24'hABCDEF;
        // last pixel of frame 3: latched; one cycle later: waits a full frame
        wait_k(4 * FRAME - 1);
        mode = 2'd0; solid_rgb = 24'h00FF00;
        wait_k(4 * FRAME);
        mode = 2'd2; solid_rgb = 24'hFF00FF;

        wait_k(258 * FRAME + 4);
        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // monitor / scoreboard
    int p, fpos, fnum;
    int last_fs = -1, last_fall = -1, low_run = 0;
    int bl_cnt, hs_cnt, vs_cnt, hs2_cnt;
    logic prev_hs = 1'b1;
    exp_t e;

    always @(negedge clk) begin
        if (mon_en && k >= 2) begin
            p    = k - 2;
            fpos = p % FRAME;
            fnum = p / FRAME;

            while (exp_q.size() > 0 && exp_q[0].pos < p) begin
                e = exp_q.pop_front();
                check({e.name, ".missed"}, 32'(p), 32'(e.pos));
            end
            if (exp_q.size() > 0 && exp_q[0].pos == p) begin
                e = exp_q.pop_front();
                check({e.name, ".hs"}, 32'(hs), 32'(e.hs));
                check({e.name, ".vs"}, 32'(vs), 32'(e.vs));
                check({e.name, ".blank_n"}, 32'(blank_n), 32'(e.bl));
                check({e.name, ".rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
                check({e.name, ".fs"}, 32'(frame_start), 32'(e.fs));
                check({e.name, ".fc"}, 32'(frame_cnt), 32'(e.fc));
                check({e.name, ".hs_pos"}, 32'(hs2), 32'(!e.hs));
                check({e.name, ".vs_pos"}, 32'(vs2), 32'(!e.vs));
                check({e.name, ".rgb_pos"}, 32'({vga_r2, vga_g2, vga_b2}), 32'(e.rgb));
                check({e.name, ".blank_n_pos"}, 32'(blank_n2), 32'(e.bl));
                check({e.name, ".fs_pos"}, 32'(frame_start2), 32'(e.fs));
                check({e.name, ".fc_pos"}, 32'(frame_cnt2), 32'(e.fc));
                if (e.bl) begin
                    check({e.name, ".x"}, 32'(x), 32'(e.px));
                    check({e.name, ".y"}, 32'(y), 32'(e.py));
                    check({e.name, ".x_pos"}, 32'(x2), 32'(e.px));
                    check({e.name, ".y_pos"}, 32'(y2), 32'(e.py));
                end
            end

            if (frame_start === 1'b1) begin
                if (last_fs >= 0) check("fs_period", 32'(p - last_fs), 32'(FRAME));
                last_fs = p;
            end

            if (fnum == 1) begin
                if (prev_hs && !hs) begin
                    if (last_fall >= 0) check("hs_period", 32'(p - last_fall), 32'(HT));
                    last_fall = p;
                    low_run = 0;
                end
                if (!hs) low_run++;
                if (!prev_hs && hs && last_fall >= 0) check("hs_width", 32'(low_run), 32'(HSY));
            end
            prev_hs = hs;

            if (fpos == 0) begin
                bl_cnt = 0; hs_cnt = 0; vs_cnt = 0; hs2_cnt = 0;
            end
            bl_cnt  += int'(blank_n);
            hs_cnt  += int'(!hs);
            vs_cnt  += int'(!vs);
            hs2_cnt += int'(hs2);
            if (fpos == FRAME - 1 && (fnum == 1 || fnum == 200)) begin
                check($sformatf("f%0d.blank_n_cycles", fnum), 32'(bl_cnt), 32'(HA * VA));
                check($sformatf("f%0d.hs_cycles", fnum), 32'(hs_cnt), 32'(HSY * VT));
                check($sformatf("f%0d.vs_cycles", fnum), 32'(vs_cnt), 32'(VSY * HT));
                check($sformatf("f%0d.hs_pos_cycles", fnum), 32'(hs2_cnt), 32'(HSY * VT));
            end
        end
    end

endmodule
